// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: dark pattern, BCD width
// and the active-low {a,b,c,d,e,f,g} glyph table for digits 0-9.
package seg_pkg;

  localparam logic [7:0] SEG_DARK = 8'hFF;
  localparam int         BCD_W    = 4;

  // Index = BCD value; bit 6 = segment a ... bit 0 = segment g, 0 = lit.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b000_0001,  // 0
    7'b100_1111,  // 1
    7'b001_0010,  // 2
    7'b000_0110,  // 3
    7'b100_1100,  // 4
    7'b010_0100,  // 5
    7'b010_0000,  // 6
    7'b000_1111,  // 7
    7'b000_0000,  // 8
    7'b000_0100   // 9
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 decode dark.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = 7'h7F;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: one digit per refresh slot with a blanking gap,
// frame-aligned double buffering of digit data and per-digit blink.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic                        load,
  output logic                        pending,
  output logic [7:0]                  seg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_tick
);

  localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0]           slot_cnt;
  logic [IDX_W-1:0]            digit_idx;
  logic [BLINK_W-1:0]          blink_cnt;
  logic                        blink_phase;
  logic [BCD_W*NUM_DIGITS-1:0] buf_bcd;
  logic [NUM_DIGITS-1:0]       buf_dp;
  logic [BCD_W*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]       shadow_dp;

  logic                  frame_end;
  logic [BCD_W-1:0]      cur_digit;
  logic [6:0]            dec_seg;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign frame_end  = (slot_cnt == SLOT_LAST) && (digit_idx == IDX_LAST);
  assign frame_tick = frame_end;
  assign cur_digit  = shadow_bcd[int'(digit_idx)*BCD_W +: BCD_W];

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Next-cycle view of the bus; the anode stays driven while a blinking digit is dark.
  always_comb begin
    an_next  = '1;
    seg_next = SEG_DARK;
    if (slot_cnt >= BLANK_END) begin
      an_next[digit_idx] = 1'b0;
      if (!(blink_phase && blink_mask[digit_idx]))
        seg_next = {dec_seg, ~shadow_dp[digit_idx]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      buf_bcd     <= '1;
      buf_dp      <= '0;
      shadow_bcd  <= '1;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      seg         <= SEG_DARK;
      an          <= '1;
    end else begin
      seg <= seg_next;
      an  <= an_next;

      if (slot_cnt == SLOT_LAST) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end

      if (frame_end) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end

      // Shadow only moves at frame end; a load on that very cycle bypasses the buffer.
      if (frame_end) begin
        if (load) begin
          shadow_bcd <= bcd_in;
          shadow_dp  <= dp_in;
        end else if (pending) begin
          shadow_bcd <= buf_bcd;
          shadow_dp  <= buf_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        buf_bcd <= bcd_in;
        buf_dp  <= dp_in;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads, every cycle
// checked against a frame-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   bcd_in = '0;
  logic [ND-1:0] dp_in = '0;
  logic [ND-1:0] blink_mask = '0;
  logic          load = 1'b0;
  logic          pending;
  logic [7:0]    seg;
  logic [ND-1:0] an;
  logic          frame_tick;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycles since reset release, shadow/buffer contents.
  int          n;
  logic [15:0] m_shadow, m_buf;
  logic [3:0]  m_sdp, m_bdp;
  bit          m_pend;
  logic [7:0]  seg_tab [16];

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .load       (load),
    .pending    (pending),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // One clock: predict outputs from the pre-edge state, advance the model, compare.
  task automatic tick();
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic [3:0] d;
    int slot, idx, frame;
    bit phase, fend;
    e_seg = 8'hFF;
    e_an  = 4'hF;
    if (rst) begin
      n = 0; m_shadow = 16'hFFFF; m_sdp = '0; m_pend = 0;
    end else begin
      slot  = n % RD;
      idx   = (n / RD) % ND;
      frame = n / FRAME;
      phase = ((frame / BF) % 2) == 1;
      fend  = (n % FRAME) == FRAME - 1;
      if (slot >= BC) begin
        e_an[idx] = 1'b0;
        d = m_shadow[idx*4 +: 4];
        if (!(phase && blink_mask[idx])) begin
          e_seg = seg_tab[d];
          if (m_sdp[idx]) e_seg[0] = 1'b0;
        end
      end
      if (fend) begin
        if (load) begin m_shadow = bcd_in; m_sdp = dp_in; end
        else if (m_pend) begin m_shadow = m_buf; m_sdp = m_bdp; end
        m_pend = 0;
      end else if (load) begin
        m_buf = bcd_in; m_bdp = dp_in; m_pend = 1;
      end
      n++;
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("an", 32'(an), 32'(e_an));
    check("pending", 32'(pending), 32'(m_pend));
    check("frame_tick", 32'(frame_tick), 32'((n % FRAME) == FRAME - 1));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    bcd_in = v; dp_in = dp; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) seg_tab[i] = 8'hFF;
    seg_tab[0] = 8'b0000_0011; seg_tab[1] = 8'b1001_1111;
    seg_tab[2] = 8'b0010_0101; seg_tab[3] = 8'b0000_1101;
    seg_tab[4] = 8'b1001_1001; seg_tab[5] = 8'b0100_1001;
    seg_tab[6] = 8'b0100_0001; seg_tab[7] = 8'b0001_1111;
    seg_tab[8] = 8'b0000_0001; seg_tab[9] = 8'b0000_1001;
    n = 0; m_shadow = 16'hFFFF; m_sdp = '0; m_buf = '0; m_bdp = '0; m_pend = 0;

    // Reset held for three cycles, then two free frames.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * FRAME);

    // Mid-frame load of 1234, shown from the next frame.
    run_to(10);
    do_load(16'h1234, 4'h0);
    check("pending_after_load", 32'(pending), 32'd1);
    run_to(0);
    run_to(3);
    check("digit0_is_4", 32'(seg), 32'h99);
    check("digit0_anode", 32'(an), 32'hE);
    run_to(27);
    check("digit3_is_1", 32'(seg), 32'h9F);
    check("digit3_anode", 32'(an), 32'h7);

    // Two loads within a frame: last wins.
    run_to(5);
    do_load(16'h1111, 4'h0);
    run(6);
    do_load(16'h5678, 4'h0);
    run(FRAME * 2);

    // Load exactly on the frame-end cycle.
    run_to(FRAME - 1);
    do_load(16'h9024, 4'h2);
    check("no_pending_on_frame_end_load", 32'(pending), 32'd0);
    run(FRAME * 2);

    // Blink on digits 0-1 across several half-periods.
    do_load(16'h1234, 4'h0);
    blink_mask = 4'b0011;
    run(FRAME * 8);
    blink_mask = 4'b0000;

    // Random loads, digit codes including 10-15, live mask changes.
    for (int it = 0; it < 40; it++) begin
      run($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) run_to(FRAME - 1);
      do_load(16'($urandom), 4'($urandom_range(0, 15)));
    end
    blink_mask = 4'b0000;
    run(FRAME * 2);

    // Code A with decimal point on digit 0, then reset mid drive-phase with data pending.
    run_to(FRAME - 1);
    do_load(16'h000A, 4'h1);
    run_to(3);
    check("dp_on_code_a", 32'(seg), 32'hFE);
    run_to(12);
    do_load(16'h4321, 4'h0);
    rst = 1'b1;
    tick();
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_an", 32'(an), 32'hF);
    check("rst_pending", 32'(pending), 32'd0);
    run(2);
    rst = 1'b0;
    run(FRAME * 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
